// File: rtl/pcm_pkg.sv
// Shared PCM datapath constants and sample types.
// Used by the overlap, window and output-serializer stages.
package pcm_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned BUS_W  = 64;

  typedef logic signed [LANE_W-1:0]  pcm_sample_t;
  typedef logic [BUS_W-1:0]          pcm_word_t;
  typedef logic [$clog2(LANES)-1:0]  lane_idx_t;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

  function automatic pcm_sample_t lane_of(pcm_word_t word, lane_idx_t idx);
    return pcm_sample_t'(word[int'(idx) * LANE_W +: LANE_W]);
  endfunction

endpackage

// File: rtl/pcm_out_serializer_if.sv
// Upstream word-load and downstream PCM sample stream bundle for pcm_out_serializer.
// The slave side is the serializer; the master side is the surrounding pipeline.
interface pcm_out_serializer_if;
  import pcm_pkg::*;

  logic        in_load;
  pcm_word_t   in_data;
  logic        in_full;
  pcm_sample_t pcm_sample;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        pcm_first;

  modport slave (
    input  in_load, in_data, pcm_ready,
    output in_full, pcm_sample, pcm_valid, pcm_first
  );

  modport master (
    output in_load, in_data, pcm_ready,
    input  in_full, pcm_sample, pcm_valid, pcm_first
  );

endinterface

// File: rtl/pcm_word_fifo.sv
// Word FIFO holding packed PCM words; exposes the head word without a read latency.
// Pointers wrap naturally because DEPTH is a power of two.
module pcm_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BUS_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [BUS_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [BUS_W-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BUS_W-1:0] mem_q [DEPTH];
  logic [BUS_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pcm_out_serializer.sv
// Serializes queued 64-bit overlap words into a 16-bit PCM stream, lane 0 first,
// with frame-start marking and a sticky overflow flag for dropped words.
module pcm_out_serializer
  import pcm_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_LEN = 1024
) (
  input  logic                clock,
  input  logic                reset,
  pcm_out_serializer_if.slave bus,
  output logic                overflow,
  input  logic                clear_ovf
);

  localparam int unsigned FRAME_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  pcm_word_t          head_word;
  logic               fifo_full, fifo_empty;
  logic               xfer, pop, drop;
  lane_idx_t          lane_idx_q, lane_idx_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               overflow_q, overflow_d;

  pcm_word_fifo #(
    .DEPTH (DEPTH),
    .BUS_W (BUS_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bus.in_load),
    .wr_data (bus.in_data),
    .rd_en   (pop),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign xfer = !fifo_empty && bus.pcm_ready;
  assign pop  = xfer && (lane_idx_q == LAST_LANE);
  assign drop = bus.in_load && fifo_full;

  always_comb begin
    lane_idx_d  = lane_idx_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    if (xfer) begin
      lane_idx_d  = lane_idx_q + lane_idx_t'(1);
      frame_cnt_d = (frame_cnt_q == FRAME_W'(FRAME_LEN - 1)) ? '0
                                                             : frame_cnt_q + FRAME_W'(1);
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (clear_ovf) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lane_idx_q  <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      lane_idx_q  <= lane_idx_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_full    = fifo_full;
  assign bus.pcm_valid  = !fifo_empty;
  assign bus.pcm_sample = fifo_empty ? '0 : lane_of(head_word, lane_idx_q);
  assign bus.pcm_first  = !fifo_empty && (frame_cnt_q == '0);
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_pcm_out_serializer.sv
// Self-checking bench for pcm_out_serializer: vector table, directed corner sequences
// and a randomized run against a sample-queue reference model.
module tb_pcm_out_serializer;
  import pcm_pkg::*;

  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 8;

  logic clock;
  logic reset;
  logic clear_ovf;
  logic overflow;

  pcm_out_serializer_if bus();

  pcm_out_serializer #(
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the stream of not-yet-transferred samples, in output order.
  logic [15:0] mq[$];
  int unsigned m_xfers;
  logic        m_ovf;
  bit          model_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  words;
    bit  drop;
    if (!reset) begin
      mq.delete();
      m_xfers  = 0;
      m_ovf    = 1'b0;
      model_on = 1;
      return;
    end
    words = (mq.size() + 3) / 4;
    drop  = 0;
    if (mq.size() != 0 && bus.pcm_ready) begin
      void'(mq.pop_front());
      m_xfers = (m_xfers + 1) % FRAME_LEN;
    end
    if (bus.in_load) begin
      if (words == DEPTH) drop = 1;
      else for (int k = 0; k < 4; k++) mq.push_back(bus.in_data[16*k +: 16]);
    end
    if (clear_ovf) m_ovf = 1'b0;
    if (drop)      m_ovf = 1'b1;
  endtask

  task automatic step();
    if (model_on) begin
      chk("m_valid",    bus.pcm_valid, mq.size() != 0);
      chk("m_sample",   {48'b0, bus.pcm_sample}, (mq.size() != 0) ? mq[0] : 16'h0);
      chk("m_first",    bus.pcm_first, (mq.size() != 0) && (m_xfers == 0));
      chk("m_in_full",  bus.in_full, ((mq.size() + 3) / 4) == DEPTH);
      chk("m_overflow", overflow, m_ovf);
    end
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.in_load   = 1'b0;
    bus.in_data   = '0;
    bus.pcm_ready = 1'b0;
    clear_ovf     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wr(input logic [63:0] w);
    bus.in_load = 1'b1;
    bus.in_data = w;
    step();
    bus.in_load = 1'b0;
  endtask

  typedef struct {
    logic        load;
    logic [63:0] data;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_sample;
    logic        exp_first;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] w2, wn;
  logic [63:0] fw[5];
  logic [63:0] cw[4];
  int          idx, n, firsts;
  bit          v;

  initial begin
    vecs[0] = '{1'b1, 64'h0004_0003_FFFE_0001, 1'b1, 1'b1, 16'h0001, 1'b1};
    vecs[1] = '{1'b0, 64'h0, 1'b1, 1'b1, 16'hFFFE, 1'b0};
    vecs[2] = '{1'b0, 64'h0, 1'b1, 1'b1, 16'h0003, 1'b0};
    vecs[3] = '{1'b0, 64'h0, 1'b1, 1'b1, 16'h0004, 1'b0};
    vecs[4] = '{1'b0, 64'h0, 1'b1, 1'b0, 16'h0000, 1'b0};

    do_reset();
    chk("rst_in_full",  bus.in_full, 1'b0);
    chk("rst_valid",    bus.pcm_valid, 1'b0);
    chk("rst_first",    bus.pcm_first, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_sample",   {48'b0, bus.pcm_sample}, 64'h0);

    // Single word, continuous ready.
    for (int i = 0; i < 5; i++) begin
      bus.in_load   = vecs[i].load;
      bus.in_data   = vecs[i].data;
      bus.pcm_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_valid", i),  bus.pcm_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_sample", i), {48'b0, bus.pcm_sample}, {48'b0, vecs[i].exp_sample});
      chk($sformatf("vec%0d_first", i),  bus.pcm_first, vecs[i].exp_first);
    end
    idle();

    // Backpressure: ready alternates 1,0.
    do_reset();
    w2 = 64'h8000_7FFF_1234_ABCD;
    wr(w2);
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      bus.pcm_ready = (i % 2 == 0);
      step();
      if (i % 2 == 0) idx++;
      chk("bp_valid", bus.pcm_valid, idx < 4);
      chk("bp_sample", {48'b0, bus.pcm_sample}, (idx < 4) ? {48'b0, w2[16*idx +: 16]} : 64'h0);
    end
    idle();

    // Fill to full with no ready; fifth write is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) fw[i] = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      wr(fw[i]);
      if (i == 2) chk("fill_not_full_3", bus.in_full, 1'b0);
      if (i == 3) chk("fill_full_4", bus.in_full, 1'b1);
    end
    chk("fill_overflow", overflow, 1'b1);
    bus.pcm_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      chk("fill_drain", {48'b0, bus.pcm_sample}, {48'b0, fw[s/4][16*(s%4) +: 16]});
      step();
    end
    chk("fill_empty", bus.pcm_valid, 1'b0);
    bus.pcm_ready = 1'b0;
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("fill_clear_ovf", overflow, 1'b0);

    // Full FIFO: lane-3 pop and write in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cw[i] = {$urandom, $urandom};
      wr(cw[i]);
    end
    chk("conc_full", bus.in_full, 1'b1);
    bus.pcm_ready = 1'b1;
    repeat (3) step();
    bus.in_load = 1'b1;
    bus.in_data = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    bus.in_load = 1'b0;
    bus.pcm_ready = 1'b0;
    chk("conc_ovf", overflow, 1'b1);
    chk("conc_cnt3", bus.in_full, 1'b0);
    chk("conc_head", {48'b0, bus.pcm_sample}, {48'b0, cw[1][15:0]});
    bus.pcm_ready = 1'b1;
    repeat (3) step();
    bus.in_load = 1'b1;
    bus.in_data = 64'h1111_2222_3333_4444;
    step();
    bus.in_load = 1'b0;
    bus.pcm_ready = 1'b0;
    chk("conc_wp_not_full", bus.in_full, 1'b0);
    chk("conc_wp_head", {48'b0, bus.pcm_sample}, {48'b0, cw[2][15:0]});
    wr(64'h5555_6666_7777_8888);
    chk("conc_cnt_was3", bus.in_full, 1'b1);
    bus.pcm_ready = 1'b1;
    repeat (17) step();
    idle();

    // Frame wrap with FRAME_LEN=8 over 12 transfers.
    do_reset();
    bus.pcm_ready = 1'b1;
    n = 0;
    firsts = 0;
    for (int c = 0; c < 16; c++) begin
      bus.in_load = (c < 3);
      bus.in_data = {$urandom, $urandom};
      v = bus.pcm_valid;
      if (v) begin
        chk("frame_first", bus.pcm_first, (n == 0) || (n == 8));
        if (bus.pcm_first) firsts++;
      end
      step();
      if (v) n++;
    end
    chk("frame_xfers", n, 12);
    chk("frame_first_count", firsts, 2);
    idle();

    // Reset mid-stream with two words queued and overflow set.
    do_reset();
    for (int i = 0; i < 5; i++) wr({$urandom, $urandom});
    bus.pcm_ready = 1'b1;
    repeat (10) step();
    bus.pcm_ready = 1'b0;
    chk("mid_pre_ovf", overflow, 1'b1);
    reset = 1'b0;
    bus.in_load = 1'b1;
    bus.in_data = 64'h0BAD_0BAD_0BAD_0BAD;
    step();
    reset = 1'b1;
    bus.in_load = 1'b0;
    chk("mid_valid", bus.pcm_valid, 1'b0);
    chk("mid_ovf", overflow, 1'b0);
    bus.pcm_ready = 1'b1;
    step();
    chk("mid_ready_noeffect", bus.pcm_valid, 1'b0);
    wn = 64'h0040_0030_0020_0010;
    wr(wn);
    chk("mid_new_valid", bus.pcm_valid, 1'b1);
    chk("mid_new_lane0", {48'b0, bus.pcm_sample}, {48'b0, wn[15:0]});
    chk("mid_new_first", bus.pcm_first, 1'b1);
    repeat (4) step();
    idle();

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.in_load   = $urandom_range(0, 1) == 1;
      bus.in_data   = {$urandom, $urandom};
      bus.pcm_ready = $urandom_range(0, 99) < (((c / 250) % 2 == 1) ? 85 : 20);
      clear_ovf     = $urandom_range(0, 15) == 0;
      reset         = $urandom_range(0, 299) != 0;
      step();
    end
    reset = 1'b1;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_out_serializer.md
PCM_OUT_SERIALIZER -- requirements
Module: pcm_out_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO depth in 64-bit words (power of two, 2..16).
REQ-002 SHALL have parameter FRAME_LEN, default 1024, meaning PCM samples per frame (multiple of 4).
REQ-003 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_load  input  1  strobe: in_data holds one overlap result word this cycle.
REQ-006 SHALL have port in_data  input  64  four signed 16-bit PCM lanes; lane k = bits [16k+15:16k].
REQ-007 SHALL have port in_full  output  1  FIFO full; upstream must not strobe in_load.
REQ-008 SHALL have port pcm_sample  output  16  current signed PCM sample.
REQ-009 SHALL have port pcm_valid  output  1  pcm_sample is valid.
REQ-010 SHALL have port pcm_ready  input  1  downstream accepts pcm_sample this cycle.
REQ-011 SHALL have port pcm_first  output  1  pcm_sample is sample 0 of a frame.
REQ-012 SHALL have port overflow  output  1  sticky: a word was dropped.
REQ-013 SHALL have port clear_ovf  input  1  clears overflow.

Function
REQ-014 Word write SHALL occur when in_load=1 and in_full=0; the word is stored at FIFO tail.
REQ-015 in_load=1 while in_full=1 SHALL discard in_data, leave FIFO unchanged and set overflow next cycle.
REQ-016 in_full SHALL be 1 exactly when word count equals DEPTH, combinationally from registered count.
REQ-017 pcm_valid SHALL be 1 exactly when word count is nonzero.
REQ-018 pcm_sample SHALL equal lane[lane_idx] of the head word; lane_idx is a 2-bit counter, lane 0 first.
REQ-019 Transfer SHALL occur when pcm_valid=1 and pcm_ready=1; lane_idx then increments; transfer at lane_idx=3 pops head and wraps lane_idx to 0.
REQ-020 With pcm_valid=0, pcm_ready SHALL have no effect and no counter SHALL change.
REQ-021 A word written into an empty FIFO at edge N SHALL be presented (pcm_valid=1, lane 0) in the cycle after edge N; latency 1 cycle.
REQ-022 Write and lane-3 pop in the same cycle SHALL both occur; count unchanged; a write when full is rejected even if a pop occurs that cycle.
REQ-023 Frame counter SHALL count transfers 0..FRAME_LEN-1 and wrap to 0.
REQ-024 pcm_first SHALL be pcm_valid AND (frame counter = 0).
REQ-025 Samples SHALL pass bit-exact; no rounding, saturation or reordering beyond lane order 0,1,2,3.
REQ-026 clear_ovf=1 SHALL clear overflow next cycle; if an overflow event occurs the same cycle, overflow SHALL remain 1.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 reset=0 at a rising edge SHALL clear word count, pointers, lane_idx, frame counter and overflow, regardless of traffic in flight.
REQ-029 After reset: in_full=0, pcm_valid=0, pcm_first=0, overflow=0, pcm_sample=0.
REQ-030 in_load during reset SHALL be ignored; stored data contents need no reset.

Structure
REQ-031 Package pcm_pkg SHALL hold LANE_W=16, LANES=4, BUS_W=64 and the signed sample typedef pcm_sample_t, shared with overlap and window stages.
REQ-032 FIFO storage, pointers and count SHALL be a sub-module pcm_word_fifo (params DEPTH, BUS_W); lane select, frame counter and overflow logic stay in pcm_out_serializer.

Verification
REQ-033 Single word: write 64'h0004_0003_FFFE_0001, pcm_ready=1 -> samples 1, -2, 3, 4 on four consecutive cycles starting 1 cycle after write; pcm_first=1 on sample 1; then pcm_valid=0.
REQ-034 Backpressure: pcm_ready toggles 1,0 -> each sample held stable while pcm_ready=0; exact order preserved; no duplication.
REQ-035 Fill: DEPTH=4, pcm_ready=0, five writes -> in_full=1 after write 4, write 5 dropped, overflow=1; drain yields 16 samples of words 1-4 only; clear_ovf -> overflow=0.
REQ-036 Concurrent: full FIFO, lane 3 transfer and in_load same cycle -> write rejected, overflow=1, count 3; with count 3, write + pop -> count stays 3.
REQ-037 Frame wrap: FRAME_LEN=8, stream 3 words continuously -> pcm_first=1 on transfers 0 and 8 only.
REQ-038 Reset mid-stream: reset=0 after lane 1 of a word with 2 words queued -> next cycle pcm_valid=0, overflow=0; new word then starts at lane 0 with pcm_first=1.
